// File: rtl/hazard_sequencer_if.sv
// rtl/hazard_sequencer_if.sv - decode-stage instruction fields and hazard-control outputs
interface hazard_sequencer_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic [REG_W-1:0] id_dest;
  logic             id_wb_en;
  logic             id_mem_r;
  logic             id_terminate;
  logic             stall;
  logic [1:0]       branch_a1_sel;
  logic [1:0]       branch_a2_sel;
  logic             halt;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_valid, id_rs, id_rt, id_dest, id_wb_en, id_mem_r, id_terminate,
    input  stall, branch_a1_sel, branch_a2_sel, halt, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_dest, id_wb_en, id_mem_r, id_terminate,
    output stall, branch_a1_sel, branch_a2_sel, halt, stall_cycles
  );
endinterface

// File: rtl/hazard_sequencer.sv
// rtl/hazard_sequencer.sv - decode-stage hazard controller: load-use stall, branch forwarding selects, terminate drain and halt
module hazard_sequencer #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               rst,
  hazard_sequencer_if.slave hz
);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             wb_en;
    logic             mem_r;
  } slot_t;

  state_e           state_q;
  slot_t            ex_q, mem_q, wb_q;
  slot_t            ex_d;
  logic             halt_q;
  logic [CNT_W-1:0] stall_cycles_q;
  logic             hazard;
  logic             stall;
  logic             accept_term;
  logic             drained;

  function automatic logic produces(input slot_t s, input logic [REG_W-1:0] r);
    return s.valid && s.wb_en && (s.dest == r) && (r != '0);
  endfunction

  // Youngest producer wins so the most recent value of the register is forwarded.
  function automatic logic [1:0] fwd_sel(input slot_t e, input slot_t m, input slot_t w,
                                         input logic [REG_W-1:0] r);
    if (produces(e, r))      return 2'd1;
    else if (produces(m, r)) return 2'd2;
    else if (produces(w, r)) return 2'd3;
    else                     return 2'd0;
  endfunction

  assign hazard = hz.id_valid && ex_q.valid && ex_q.mem_r && ex_q.wb_en && (ex_q.dest != '0)
                  && ((ex_q.dest == hz.id_rs) || (ex_q.dest == hz.id_rt));

  assign stall       = (state_q != RUN) || hazard;
  assign accept_term = (state_q == RUN) && hz.id_valid && hz.id_terminate && !hazard;
  assign drained     = !ex_q.valid && !mem_q.valid && !wb_q.valid;

  // The accepted terminate itself never enters EX; a bubble takes its place.
  always_comb begin
    ex_d = '0;
    if (hz.id_valid && !stall && !accept_term) begin
      ex_d.valid = 1'b1;
      ex_d.dest  = hz.id_dest;
      ex_d.wb_en = hz.id_wb_en;
      ex_d.mem_r = hz.id_mem_r;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      ex_q           <= '0;
      mem_q          <= '0;
      wb_q           <= '0;
      halt_q         <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
      if (stall && (stall_cycles_q != '1)) begin
        stall_cycles_q <= stall_cycles_q + 1'b1;
      end
      case (state_q)
        RUN: begin
          if (accept_term) state_q <= DRAIN;
        end
        DRAIN: begin
          if (drained) begin
            state_q <= HALTED;
            halt_q  <= 1'b1;
          end
        end
        HALTED: begin
          halt_q <= 1'b1;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  assign hz.stall         = stall;
  assign hz.branch_a1_sel = fwd_sel(ex_q, mem_q, wb_q, hz.id_rs);
  assign hz.branch_a2_sel = fwd_sel(ex_q, mem_q, wb_q, hz.id_rt);
  assign hz.halt          = halt_q;
  assign hz.stall_cycles  = stall_cycles_q;
endmodule
